// File: rtl/pixie_dma_ctrl.sv
// Pixie (CDP1861-style) timing and DMA sequencer: machine-cycle/line counters,
// CPU-facing INT/EFX/DMA-request generation and frame-buffer write capture.
module pixie_dma_ctrl #(
    parameter int CYCLES_PER_LINE = 14,
    parameter int LINES_PER_FRAME = 262,
    parameter int FIRST_DMA_LINE  = 64,
    parameter int DMA_LINES       = 128,
    parameter int DMA_START_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cyc_en,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic       dma_strobe,
    input  logic [7:0] dma_data,
    output logic       dma_req,
    output logic       int_n,
    output logic       efx_n,
    output logic       fb_en,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       frame_done
);

    localparam int CYC_W  = $clog2(CYCLES_PER_LINE);
    localparam int LINE_W = $clog2(LINES_PER_FRAME);
    localparam int ADDR_W = 10;
    localparam int REL_W  = ADDR_W - 3;

    localparam logic [CYC_W-1:0]  CYC_LAST      = CYC_W'(CYCLES_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST     = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [LINE_W-1:0] DMA_LAST_LINE = LINE_W'(FIRST_DMA_LINE + DMA_LINES - 1);
    localparam logic [LINE_W-1:0] DMA_FIRST     = LINE_W'(FIRST_DMA_LINE);

    logic [CYC_W-1:0]  cyc_cnt_q,  cyc_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic              disp_req_q, disp_req_d;
    logic              frame_en_q, frame_en_d;
    logic              dma_req_q,  dma_req_d;
    logic              int_n_q,    int_n_d;
    logic              efx_n_q,    efx_n_d;
    logic              fb_en_q,    fb_en_d;
    logic [ADDR_W-1:0] fb_addr_q,  fb_addr_d;
    logic [7:0]        fb_data_q,  fb_data_d;
    logic              frame_done_q, frame_done_d;

    logic              accept;
    logic [REL_W-1:0]  rel_line;

    function automatic logic line_in(input logic [LINE_W-1:0] l, input int lo, input int hi);
        return (int'(l) >= lo) && (int'(l) <= hi);
    endfunction

    function automatic logic cyc_in(input logic [CYC_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

    // Line/cycle counters and display enable; frame_en only changes at frame start.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        cyc_cnt_d  = cyc_cnt_q;
        line_cnt_d = line_cnt_q;
        frame_en_d = frame_en_q;
        if (cyc_en) begin
            if (cyc_cnt_q == '0 && line_cnt_q == '0) begin
                frame_en_d = disp_req_q;
            end
            if (cyc_cnt_q == CYC_LAST) begin
                cyc_cnt_d  = '0;
                line_cnt_d = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + 1'b1;
            end else begin
                cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
        end
        disp_req_d = disp_off ? 1'b0 : (disp_on ? 1'b1 : disp_req_q);
    end

    // Byte capture uses the pre-update request and counters, so a strobe on the
    // cyc_en that opens the window is still rejected.
    always_comb begin
        accept     = dma_strobe && dma_req_q && (byte_cnt_q < 4'd8);
        rel_line   = REL_W'(line_cnt_q - DMA_FIRST);
        byte_cnt_d = byte_cnt_q;
        fb_en_d    = accept;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            fb_addr_d  = {rel_line, byte_cnt_q[2:0]};
            fb_data_d  = dma_data;
        end
        if (cyc_en && cyc_cnt_d == '0) begin
            byte_cnt_d = '0;
        end
    end

    // CPU-facing timing outputs, evaluated on the post-increment counters.
    always_comb begin
        dma_req_d = dma_req_q;
        int_n_d   = int_n_q;
        efx_n_d   = efx_n_q;
        if (cyc_en) begin
            dma_req_d = frame_en_d
                        && line_in(line_cnt_d, FIRST_DMA_LINE, FIRST_DMA_LINE + DMA_LINES - 1)
                        && cyc_in(cyc_cnt_d, DMA_START_CYC, DMA_START_CYC + 7);
            int_n_d   = !(frame_en_d
                        && line_in(line_cnt_d, FIRST_DMA_LINE - 2, FIRST_DMA_LINE - 1));
            efx_n_d   = !(frame_en_d
                        && (line_in(line_cnt_d, FIRST_DMA_LINE - 4, FIRST_DMA_LINE - 1)
                         || line_in(line_cnt_d, FIRST_DMA_LINE + DMA_LINES - 4,
                                    FIRST_DMA_LINE + DMA_LINES - 1)));
        end
        frame_done_d = dma_req_q && !dma_req_d && (line_cnt_q == DMA_LAST_LINE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_q    <= '0;
            line_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            disp_req_q   <= 1'b0;
            frame_en_q   <= 1'b0;
            dma_req_q    <= 1'b0;
            int_n_q      <= 1'b1;
            efx_n_q      <= 1'b1;
            fb_en_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            cyc_cnt_q    <= cyc_cnt_d;
            line_cnt_q   <= line_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            disp_req_q   <= disp_req_d;
            frame_en_q   <= frame_en_d;
            dma_req_q    <= dma_req_d;
            int_n_q      <= int_n_d;
            efx_n_q      <= efx_n_d;
            fb_en_q      <= fb_en_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dma_req    = dma_req_q;
    assign int_n      = int_n_q;
    assign efx_n      = efx_n_q;
    assign fb_en      = fb_en_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixie_dma_ctrl.sv
// Self-checking bench for pixie_dma_ctrl: a frame-position reference model checked
// every clock, plus directed per-frame expectations written as literal numbers.
module tb_pixie_dma_ctrl;

    localparam int CPL   = 14;
    localparam int LPF   = 262;
    localparam int FIRST = 64;
    localparam int NLIN  = 128;
    localparam int START = 2;
    localparam int LAST  = FIRST + NLIN - 1;
    localparam int LIMIT = 20000;
    localparam int MODE_FULL = 0;
    localparam int MODE_RAND = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cyc_en, disp_on, disp_off, dma_strobe;
    logic [7:0] dma_data;
    logic       dma_req, int_n, efx_n, fb_en, frame_done;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    pixie_dma_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cyc_en     (cyc_en),
        .disp_on    (disp_on),
        .disp_off   (disp_off),
        .dma_strobe (dma_strobe),
        .dma_data   (dma_data),
        .dma_req    (dma_req),
        .int_n      (int_n),
        .efx_n      (efx_n),
        .fb_en      (fb_en),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit between(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Reference model: position in frame as a single machine-cycle index.
    int m_pos, m_line, m_cyc, m_bytes;
    bit m_disp, m_fen;
    bit e_dma, e_int_n, e_efx_n, e_fb_en, e_done;
    int e_addr, e_data;
    int m_pre_line;
    bit m_pre_dma;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos = 0; m_line = 0; m_cyc = 0; m_bytes = 0;
            m_disp = 0; m_fen = 0;
            e_dma = 0; e_int_n = 1; e_efx_n = 1; e_fb_en = 0; e_done = 0;
            e_addr = 0; e_data = 0;
        end else begin
            m_pre_line = m_line;
            m_pre_dma  = e_dma;
            e_fb_en = dma_strobe && e_dma && (m_bytes < 8);
            if (e_fb_en) begin
                e_addr = (m_line - FIRST) * 8 + m_bytes;
                e_data = int'(dma_data);
                m_bytes++;
            end
            if (cyc_en) begin
                if (m_pos == 0) m_fen = m_disp;
                m_pos  = (m_pos + 1) % (CPL * LPF);
                m_line = m_pos / CPL;
                m_cyc  = m_pos % CPL;
                if (m_cyc == 0) m_bytes = 0;
                e_dma   = m_fen && between(m_line, FIRST, LAST) && between(m_cyc, START, START + 7);
                e_int_n = !(m_fen && between(m_line, FIRST - 2, FIRST - 1));
                e_efx_n = !(m_fen && (between(m_line, FIRST - 4, FIRST - 1) ||
                                      between(m_line, LAST - 3, LAST)));
            end
            e_done = m_pre_dma && !e_dma && (m_pre_line == LAST);
            if (disp_off)     m_disp = 0;
            else if (disp_on) m_disp = 1;
        end
    end

    // Observation log of DUT behaviour, cleared per phase by the main sequence.
    typedef struct { int line; int cyc; int addr; int data; } wr_t;
    wr_t wr_q[$];
    wr_t cur_wr;
    bit  int_low[LPF];
    bit  efx_low[LPF];
    bit  dma_line[LPF];
    int  dma_clks, dma_cyc_min, dma_cyc_max, done_cnt, done_line;

    always @(negedge clk) begin
        check("outputs{dma,int_n,efx_n,fb_en,done}",
              32'({dma_req, int_n, efx_n, fb_en, frame_done}),
              32'({e_dma, e_int_n, e_efx_n, e_fb_en, e_done}));
        if (e_fb_en) begin
            check("fb_addr", 32'(fb_addr), 32'(e_addr));
            check("fb_data", 32'(fb_data), 32'(e_data));
        end
        if (int_n === 1'b0) int_low[m_line] = 1;
        if (efx_n === 1'b0) efx_low[m_line] = 1;
        if (dma_req === 1'b1) begin
            dma_line[m_line] = 1;
            dma_clks++;
            if (m_cyc < dma_cyc_min) dma_cyc_min = m_cyc;
            if (m_cyc > dma_cyc_max) dma_cyc_max = m_cyc;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_line = m_line;
        end
        if (fb_en === 1'b1) begin
            cur_wr.line = m_line;
            cur_wr.cyc  = m_cyc;
            cur_wr.addr = int'(fb_addr);
            cur_wr.data = int'(fb_data);
            wr_q.push_back(cur_wr);
        end
    end

    task automatic clear_stats();
        for (int l = 0; l < LPF; l++) begin
            int_low[l] = 0; efx_low[l] = 0; dma_line[l] = 0;
        end
        wr_q.delete();
        dma_clks = 0; dma_cyc_min = 99; dma_cyc_max = -1;
        done_cnt = 0; done_line = -1;
    endtask

    // Stimulus driver: one call advances one clock, then drives the next inputs.
    int gap = 3;
    bit req_on, req_off;
    int mode = MODE_FULL;
    bit directed;
    int line_strobes;
    int last_line = -1;

    task automatic tick();
        @(posedge clk);
        #1;
        disp_on  = req_on;
        disp_off = req_off;
        req_on   = 0;
        req_off  = 0;
        cyc_en   = (gap == 0);
        gap      = cyc_en ? $urandom_range(1, 2) : gap - 1;
        if (m_line != last_line) begin
            last_line    = m_line;
            line_strobes = 0;
        end
        dma_strobe = 1'b0;
        dma_data   = 8'($urandom);
        if (directed && (m_line == 70 || m_line == 71)) begin
            dma_strobe = between(m_cyc, START, START + 7) &&
                         (line_strobes < ((m_line == 70) ? 10 : 3));
        end else if (directed && m_line == 73) begin
            dma_strobe = cyc_en && between(m_cyc, START - 1, START + 7);
            dma_data   = 8'hA0 | 8'(m_cyc);
        end else if (mode == MODE_FULL || (directed && m_line == 72)) begin
            dma_strobe = cyc_en && between(m_cyc, START, START + 7);
            dma_data   = {m_line[4:0], 3'(m_cyc - START)};
        end else begin
            dma_strobe = ($urandom_range(0, 1) == 1);
        end
        if (dma_strobe) line_strobes++;
    endtask

    task automatic wait_pos(input int line, input int cyc, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(m_line == line && m_cyc == cyc) && n < LIMIT);
        check({"reach ", tag}, 32'(m_line * CPL + m_cyc), 32'(line * CPL + cyc));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dma_req"},    32'(dma_req),    32'd0);
        check({tag, " int_n"},      32'(int_n),      32'd1);
        check({tag, " efx_n"},      32'(efx_n),      32'd1);
        check({tag, " fb_en"},      32'(fb_en),      32'd0);
        check({tag, " fb_addr"},    32'(fb_addr),    32'd0);
        check({tag, " fb_data"},    32'(fb_data),    32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bad, n, first_dma;
        int  l70[$], l71[$], l72[$];
        wr_t l73[$];

        cyc_en = 0; disp_on = 0; disp_off = 0; dma_strobe = 0; dma_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset_n = 1'b1;

        // Frame 0: display on before the first machine cycle, strobe every window cycle.
        clear_stats();
        req_on = 1;
        wait_pos(1, 0, "f0 line1");
        wait_pos(0, 0, "f0 end");
        check("f0 write count", 32'(wr_q.size()), 32'd1024);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i].addr != i) bad++;
        check("f0 addr order", 32'(bad), 32'd0);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i].data != ((FIRST + i / 8) % 32) * 8 + i % 8) bad++;
        check("f0 data", 32'(bad), 32'd0);
        check("f0 frame_done count", 32'(done_cnt), 32'd1);
        check("f0 frame_done line", 32'(done_line), 32'd191);
        bad = 0;
        for (int l = 0; l < LPF; l++) if (int_low[l] != (l == 62 || l == 63)) bad++;
        check("f0 int_n lines", 32'(bad), 32'd0);
        bad = 0;
        for (int l = 0; l < LPF; l++)
            if (efx_low[l] != ((l >= 60 && l <= 63) || (l >= 188 && l <= 191))) bad++;
        check("f0 efx_n lines", 32'(bad), 32'd0);
        bad = 0;
        for (int l = 0; l < LPF; l++) if (dma_line[l] != (l >= 64 && l <= 191)) bad++;
        check("f0 dma_req lines", 32'(bad), 32'd0);
        check("f0 dma_req first cyc", 32'(dma_cyc_min), 32'd2);
        check("f0 dma_req last cyc", 32'(dma_cyc_max), 32'd9);

        // Frame 1: random strobes plus directed lines; display turned off mid-frame.
        clear_stats();
        mode = MODE_RAND;
        directed = 1;
        wait_pos(100, 0, "f1 line100");
        req_off = 1;
        wait_pos(150, 0, "f1 line150");
        req_on = 1;
        req_off = 1;
        wait_pos(0, 0, "f1 end");
        directed = 0;
        foreach (wr_q[i]) begin
            case (wr_q[i].line)
                70: l70.push_back(wr_q[i].addr);
                71: l71.push_back(wr_q[i].addr);
                72: l72.push_back(wr_q[i].addr);
                73: l73.push_back(wr_q[i]);
                default: ;
            endcase
        end
        check("l70 write count", 32'(l70.size()), 32'd8);
        bad = 0;
        foreach (l70[k]) if (l70[k] != 48 + k) bad++;
        check("l70 addrs 48..55", 32'(bad), 32'd0);
        check("l71 write count", 32'(l71.size()), 32'd3);
        bad = 0;
        foreach (l71[k]) if (l71[k] != 56 + k) bad++;
        check("l71 addrs 56..58", 32'(bad), 32'd0);
        check("l72 first addr", 32'((l72.size() > 0) ? l72[0] : -1), 32'd64);
        check("l73 write count", 32'(l73.size()), 32'd8);
        check("l73 first data (cyc2 strobe)", 32'((l73.size() > 0) ? l73[0].data : -1), 32'hA2);
        check("l73 byte7 addr", 32'((l73.size() > 0) ? l73[l73.size() - 1].addr : -1), 32'd79);
        check("l73 byte7 data (cyc9 strobe)",
              32'((l73.size() > 0) ? l73[l73.size() - 1].data : -1), 32'hA9);
        check("f1 frame_done count", 32'(done_cnt), 32'd1);

        // Frame 2: disabled; display re-requested at line 100.
        clear_stats();
        wait_pos(100, 0, "f2 line100");
        req_on = 1;
        wait_pos(0, 0, "f2 end");
        check("f2 dma_req clocks", 32'(dma_clks), 32'd0);
        check("f2 writes", 32'(wr_q.size()), 32'd0);
        check("f2 frame_done", 32'(done_cnt), 32'd0);
        bad = 0;
        for (int l = 0; l < LPF; l++) if (int_low[l] || efx_low[l]) bad++;
        check("f2 int/efx idle", 32'(bad), 32'd0);

        // Frame 3: enabled again; reset during the byte-4 write of line 80.
        clear_stats();
        mode = MODE_FULL;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(m_line == 80 && e_fb_en && e_addr == 132) && n < LIMIT);
        check("reach line80 byte4 write", 32'(m_line == 80 && e_fb_en && e_addr == 132), 32'd1);
        first_dma = -1;
        for (int l = LPF - 1; l >= 0; l--) if (dma_line[l]) first_dma = l;
        check("f3 first dma_req line", 32'(first_dma), 32'd64);
        check("pre-reset fb_en", 32'(fb_en), 32'd1);
        check("pre-reset fb_addr", 32'(fb_addr), 32'd132);
        #1;
        reset_n    = 1'b0;
        cyc_en     = 1'b0;
        dma_strobe = 1'b0;
        #1;
        check_reset_outputs("mid-line reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // After reset: nothing until a new disp_on and a new frame start.
        clear_stats();
        wait_pos(1, 0, "post-reset line1");
        wait_pos(200, 0, "post-reset line200");
        req_on = 1;
        wait_pos(0, 0, "post-reset end");
        check("post-reset frame writes", 32'(wr_q.size()), 32'd0);
        check("post-reset frame dma_req", 32'(dma_clks), 32'd0);
        clear_stats();
        wait_pos(100, 0, "re-enabled line100");
        check("re-enabled writes by line100", 32'(wr_q.size()), 32'd288);
        check("re-enabled first addr", 32'((wr_q.size() > 0) ? wr_q[0].addr : -1), 32'd0);
        check("re-enabled frame_done", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
